mem_stage_unit: RTL and testbench
=================================

// Module: mem_stage_unit
// PURPOSE
// - Memory stage of the 8-bit pipelined CPU. Consumes the EXE/MEM pipeline register outputs and performs
//   the data-memory access with WAIT_CYCLES wait states.
// - Raises stall to freeze upstream stages while an access is in progress.
// - Drives the registered MEM/WB values: regWr, rd, write-back data.
// PARAMETERS
// - DATA_W       8    data / ALU result width
// - REG_W        3    register-file address width
// - DEPTH        256  data-memory words; addressed by aluRes_in[7:0]
// - WAIT_CYCLES  2    extra cycles per memory access; 0 gives single-cycle access
// PORTS
// - clk           in   1       clock; all state updates on posedge
// - rst           in   1       reset, asynchronous, active-low
// - regWr_in      in   1       register write enable from EXE/MEM
// - memWr_in      in   1       store request
// - memRd_in      in   1       load request
// - aluRes_in     in   DATA_W  ALU result; memory address for load/store
// - memWrData_in  in   DATA_W  store data
// - rd_in         in   REG_W   destination register
// - stall         out  1       hold EXE/MEM and earlier stages (combinational from state)
// - regWr_out     out  1       MEM/WB register write enable
// - rd_out        out  REG_W   MEM/WB destination register
// - wbData_out    out  DATA_W  MEM/WB write-back data (load data, else aluRes)
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, counter=0, stall=0, regWr_out=0, rd_out=0, wbData_out=0.
//   The memory array is not cleared.
// - FSM has two states: IDLE and BUSY. The latched op (regWr, rd, addr, wdata, rd/wr kind) is held
//   in internal registers.
// - IDLE, no memRd/memWr: stall=0. Next edge: regWr_out<=regWr_in, rd_out<=rd_in, wbData_out<=aluRes_in.
//   Latency is 1.
// - IDLE, mem op, WAIT_CYCLES=0: behaves as BUSY with counter=0. stall=0; the access completes at this edge.
// - IDLE, mem op, WAIT_CYCLES>0: stall=1. Next edge: latch op, counter<=WAIT_CYCLES-1, go to BUSY,
//   regWr_out<=0 (bubble).
// - BUSY, counter!=0: stall=1; counter decrements; regWr_out<=0 (bubble); EXE/MEM inputs are ignored.
// - BUSY, counter==0: stall=0. At the edge:
//   - a store writes mem[addr]<=wdata;
//   - a load drives wbData_out<=mem[addr];
//   - a store drives wbData_out<=addr;
//   - regWr_out and rd_out come from the latched op;
//   - the FSM returns to IDLE.
// - Upstream advances on this same edge, so the next op is presented in IDLE.
// - A memory op therefore takes WAIT_CYCLES+1 cycles, with stall high for exactly WAIT_CYCLES cycles.
// - memRd_in and memWr_in both high: treated as a store. No read data is returned; wbData_out=aluRes.
// - Back-to-back memory ops: each op pays the full wait. There is no pipelining of accesses.
// - Reset during BUSY: the op is aborted, no memory write occurs, and all outputs go to their reset values.
// - Address: full aluRes_in; the index wraps modulo DEPTH.
// - Memory read is asynchronous; the value is sampled into wbData_out at the completing edge.
// STRUCTURE
// - Shared package holds DATA_W, REG_W, and the state enum {IDLE, BUSY}.
// - Sub-module data_mem: DEPTH x DATA_W array with sync write (we, addr, wdata) and async read (addr -> rdata).
// - Top level holds the FSM, the wait counter (width clog2(WAIT_CYCLES+1)), the op latch, and the MEM/WB registers.
// TESTING
// - ALU op regWr=1, rd=3, aluRes=0x5A -> next edge regWr_out=1, rd_out=3, wbData_out=0x5A; stall stays 0.
// - Store addr 0x10, data 0xA5 (WAIT_CYCLES=2) -> stall=1 for 2 cycles; regWr_out=0 during the stall.
// - Load addr 0x10, rd=2 after that store -> on the 3rd edge wbData_out=0xA5, rd_out=2, regWr_out=1.
// - During the stall, change inputs to aluRes=0x77, memWr=1 -> ignored; mem[0x77] is unchanged;
//   the original op completes.
// - Write mem[0x20]=0x11, then start a store 0x20<-0x99 and assert rst=0 while BUSY ->
//   stall=0 and all outputs 0 immediately; a later load of 0x20 returns 0x11.
// - WAIT_CYCLES=0: store then load addr 0xFF -> stall never asserted; the load result appears 1 edge
//   after presentation.

Source files
------------

// File: rtl/mem_stage_unit_pkg.sv
// Shared widths, FSM state encoding and the latched memory-op record for the memory stage.
package mem_stage_unit_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One memory-stage operation as seen on the EXE/MEM register; wr=1 marks a store.
  typedef struct packed {
    logic              regwr;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
  } op_t;

endpackage

// File: rtl/mem_stage_unit_data_mem.sv
// Data memory: DEPTH x DATA_W words, synchronous write, asynchronous read.
// The address wraps modulo DEPTH (DEPTH is a power of two).
module mem_stage_unit_data_mem
  import mem_stage_unit_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     idx;

  assign idx   = addr[AW-1:0];
  assign rdata = mem_q[idx];

  // Write port; contents are deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage of the 8-bit pipelined CPU: performs data-memory accesses with
// WAIT_CYCLES wait states, stalls upstream while busy and drives MEM/WB registers.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWr_in,
  input  logic              memWr_in,
  input  logic              memRd_in,
  input  logic [DATA_W-1:0] aluRes_in,
  input  logic [DATA_W-1:0] memWrData_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              stall,
  output logic              regWr_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [DATA_W-1:0] wbData_out
);

  // A zero-width counter is illegal, so zero-wait builds keep one unused bit.
  localparam int              CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  op_t               op_q;
  logic              regwr_q;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] wb_q;

  op_t               op_in;
  op_t               cur_op;
  logic              mem_op_in;
  logic              done;
  logic              mem_we;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] done_wb;

  assign op_in = '{regwr: regWr_in, rd: rd_in, addr: aluRes_in,
                   wdata: memWrData_in, wr: memWr_in};
  assign mem_op_in = memRd_in | memWr_in;

  // The op that completes this cycle: the latched one when BUSY, otherwise the
  // incoming one (only reaches completion from IDLE in zero-wait builds).
  assign cur_op  = (state_q == BUSY) ? op_q : op_in;
  assign done    = (state_q == BUSY) ? (cnt_q == '0)
                                     : (mem_op_in && (WAIT_CYCLES == 0));
  // Reset gating keeps an aborted store from landing on a clock edge during reset.
  assign mem_we  = rst & done & cur_op.wr;
  assign done_wb = cur_op.wr ? cur_op.addr : rdata;

  // Stall while wait states remain; forced low during reset so upstream is released.
  assign stall = rst & ((state_q == BUSY) ? (cnt_q != '0)
                                          : (mem_op_in && (WAIT_CYCLES > 0)));

  assign regWr_out  = regwr_q;
  assign rd_out     = rd_q;
  assign wbData_out = wb_q;

  mem_stage_unit_data_mem #(.DEPTH(DEPTH)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cur_op.addr),
    .wdata (cur_op.wdata),
    .rdata (rdata)
  );

  // FSM, wait counter, op latch and MEM/WB registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      regwr_q <= 1'b0;
      rd_q    <= '0;
      wb_q    <= '0;
    end else if (state_q == IDLE) begin
      if (mem_op_in && (WAIT_CYCLES > 0)) begin
        op_q    <= op_in;
        cnt_q   <= CNT_INIT;
        state_q <= BUSY;
        regwr_q <= 1'b0;
      end else if (done) begin
        regwr_q <= cur_op.regwr;
        rd_q    <= cur_op.rd;
        wb_q    <= done_wb;
      end else begin
        regwr_q <= regWr_in;
        rd_q    <= rd_in;
        wb_q    <= aluRes_in;
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_q   <= cnt_q - CNT_W'(1);
        regwr_q <= 1'b0;
      end else begin
        regwr_q <= cur_op.regwr;
        rd_q    <= cur_op.rd;
        wb_q    <= done_wb;
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: a 2-wait-state instance and a zero-wait instance
// driven by a directed table, a reset-abort sequence and random ops vs a memory model.
module tb_mem_stage_unit;
  import mem_stage_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       regWr_i [2];
  logic       memWr_i [2];
  logic       memRd_i [2];
  logic [7:0] alu_i   [2];
  logic [7:0] wd_i    [2];
  logic [2:0] rd_i    [2];
  logic       stall_o [2];
  logic       regWr_o [2];
  logic [2:0] rd_o    [2];
  logic [7:0] wb_o    [2];

  mem_stage_unit #(.DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .regWr_in(regWr_i[0]), .memWr_in(memWr_i[0]),
    .memRd_in(memRd_i[0]), .aluRes_in(alu_i[0]), .memWrData_in(wd_i[0]),
    .rd_in(rd_i[0]), .stall(stall_o[0]), .regWr_out(regWr_o[0]),
    .rd_out(rd_o[0]), .wbData_out(wb_o[0]));

  mem_stage_unit #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .regWr_in(regWr_i[1]), .memWr_in(memWr_i[1]),
    .memRd_in(memRd_i[1]), .aluRes_in(alu_i[1]), .memWrData_in(wd_i[1]),
    .rd_in(rd_i[1]), .stall(stall_o[1]), .regWr_out(regWr_o[1]),
    .rd_out(rd_o[1]), .wbData_out(wb_o[1]));

  int checks = 0;
  int errors = 0;
  int WC [2] = '{2, 0};
  logic [7:0] ref_mem [2][256];

  typedef struct {
    int         d;
    logic       regwr, wr, rdq;
    logic [7:0] alu, wdata;
    logic [2:0] rd;
    logic       exp_regwr;
    logic [2:0] exp_rd;
    logic [7:0] exp_wb;
    int         exp_stall;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic set_idle(input int d);
    regWr_i[d] = 1'b0; memWr_i[d] = 1'b0; memRd_i[d] = 1'b0;
    alu_i[d] = 8'h00; wd_i[d] = 8'h00; rd_i[d] = 3'd0;
  endtask

  // Present one op just after a posedge, follow the stall handshake, then
  // return what the MEM/WB registers hold after the completing edge.
  task automatic do_op(input int d, input logic regwr, input logic wr, input logic rdq,
                       input logic [7:0] alu, input logic [7:0] wdata, input logic [2:0] rd,
                       output logic g_regwr, output logic [2:0] g_rd, output logic [7:0] g_wb,
                       output int ncyc);
    bit fin = 0;
    regWr_i[d] = regwr; memWr_i[d] = wr; memRd_i[d] = rdq;
    alu_i[d] = alu; wd_i[d] = wdata; rd_i[d] = rd;
    ncyc = 0;
    for (int k = 0; k < 20 && !fin; k++) begin
      @(negedge clk);
      if (!stall_o[d]) fin = 1;
      else begin
        ncyc++;
        if (ncyc >= 2) chk("bubble_regwr", regWr_o[d], 1'b0);
        @(posedge clk); #1;
        // Garbage on the inputs while busy must not disturb the latched op.
        if (d == 0 && ncyc == 1) begin
          regWr_i[0] = 1'b1; memWr_i[0] = 1'b1; memRd_i[0] = 1'b0;
          alu_i[0] = 8'h77; wd_i[0] = 8'hEE; rd_i[0] = 3'd7;
        end
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL op_timeout dut=%0d got=stall_stuck exp=release", d);
    end
    @(posedge clk); #1;
    g_regwr = regWr_o[d]; g_rd = rd_o[d]; g_wb = wb_o[d];
    set_idle(d);
  endtask

  initial begin
    logic       g_regwr;
    logic [2:0] g_rd;
    logic [7:0] g_wb;
    int         ncyc;

    set_idle(0); set_idle(1);
    rst = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stall", stall_o[d], 1'b0);
      chk("rst_regwr", regWr_o[d], 1'b0);
      chk("rst_rd", rd_o[d], 3'd0);
      chk("rst_wb", wb_o[d], 8'h00);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // d, regwr, wr, rdq, alu, wdata, rd, exp_regwr, exp_rd, exp_wb, exp_stall
    vt[0]  = '{0, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 3'd3, 1'b1, 3'd3, 8'h5A, 0};
    vt[1]  = '{0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h33, 3'd0, 1'b0, 3'd0, 8'h77, 2};
    vt[2]  = '{0, 1'b0, 1'b1, 1'b0, 8'h10, 8'hA5, 3'd1, 1'b0, 3'd1, 8'h10, 2};
    vt[3]  = '{0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2, 1'b1, 3'd2, 8'hA5, 2};
    vt[4]  = '{0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h00, 3'd4, 1'b1, 3'd4, 8'h33, 2};
    vt[5]  = '{0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h5C, 3'd5, 1'b1, 3'd5, 8'h40, 2};
    vt[6]  = '{0, 1'b1, 1'b0, 1'b1, 8'h40, 8'h00, 3'd1, 1'b1, 3'd1, 8'h5C, 2};
    vt[7]  = '{0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h00, 3'd6, 1'b0, 3'd6, 8'hC3, 0};
    vt[8]  = '{1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h3C, 3'd0, 1'b0, 3'd0, 8'hFF, 0};
    vt[9]  = '{1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 3'd4, 1'b1, 3'd4, 8'h3C, 0};
    vt[10] = '{1, 1'b1, 1'b0, 1'b0, 8'h81, 8'h00, 3'd7, 1'b1, 3'd7, 8'h81, 0};

    for (int i = 0; i < 11; i++) begin
      do_op(vt[i].d, vt[i].regwr, vt[i].wr, vt[i].rdq, vt[i].alu, vt[i].wdata, vt[i].rd,
            g_regwr, g_rd, g_wb, ncyc);
      chk($sformatf("vec%0d_regwr", i), g_regwr, vt[i].exp_regwr);
      chk($sformatf("vec%0d_rd", i), g_rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_wb", i), g_wb, vt[i].exp_wb);
      chk($sformatf("vec%0d_stall_cycles", i), ncyc, vt[i].exp_stall);
    end

    // Reset while a store is in flight: outputs clear at once, memory keeps old data.
    do_op(0, 1'b0, 1'b1, 1'b0, 8'h20, 8'h11, 3'd0, g_regwr, g_rd, g_wb, ncyc);
    chk("pre_store_wb", g_wb, 8'h20);
    regWr_i[0] = 1'b1; memWr_i[0] = 1'b1; alu_i[0] = 8'h20; wd_i[0] = 8'h99; rd_i[0] = 3'd6;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy_stall", stall_o[0], 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("abort_stall", stall_o[0], 1'b0);
    chk("abort_regwr", regWr_o[0], 1'b0);
    chk("abort_rd", rd_o[0], 3'd0);
    chk("abort_wb", wb_o[0], 8'h00);
    @(posedge clk); #1;
    set_idle(0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_op(0, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 3'd2, g_regwr, g_rd, g_wb, ncyc);
    chk("abort_load_wb", g_wb, 8'h11);
    chk("abort_load_rd", g_rd, 3'd2);

    // Random ops over a small address pool, checked against an array model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] a, v;
        a = 8'(i * 17 + 3);
        v = 8'($urandom);
        do_op(d, 1'b0, 1'b1, 1'b0, a, v, 3'd0, g_regwr, g_rd, g_wb, ncyc);
        ref_mem[d][a] = v;
        chk("pool_store_wb", g_wb, a);
      end
      for (int n = 0; n < 60; n++) begin
        int         kind;
        logic       rw, wr, rdq;
        logic [7:0] a, v, ewb;
        logic [2:0] rd;
        kind = int'($urandom_range(0, 3));
        rw = 1'($urandom); rd = 3'($urandom); v = 8'($urandom);
        a = (kind == 0) ? 8'($urandom) : 8'(int'($urandom_range(0, 15)) * 17 + 3);
        wr  = (kind >= 2);
        rdq = (kind == 1) || (kind == 3);
        if (kind == 1) ewb = ref_mem[d][a];
        else ewb = a;
        do_op(d, rw, wr, rdq, a, v, rd, g_regwr, g_rd, g_wb, ncyc);
        if (wr) ref_mem[d][a] = v;
        chk($sformatf("rnd%0d_%0d_regwr", d, n), g_regwr, rw);
        chk($sformatf("rnd%0d_%0d_rd", d, n), g_rd, rd);
        chk($sformatf("rnd%0d_%0d_wb", d, n), g_wb, ewb);
        chk($sformatf("rnd%0d_%0d_stall", d, n), ncyc, (kind == 0) ? 0 : WC[d]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
